// File: rtl/sys_defs.sv
// Shared definitions for the FV memory subsystem.
//  - Geometry of one FV bank and of the words streamed to the PEs.
//  - FV_MEM_CNTL2FV_Bank_CNTL: routed request from the FV memory controller.
//  - FV_Bank_CNTL2PE: word stream from a bank responder to the PE side.
//  - fv_bank_state_t: state of the per-bank read responder.
package sys_defs;

  localparam int Num_Banks_FV = 4;

  localparam int PE_TAG_W     = 2;
  localparam int BANK_ADDR_W  = 2;
  localparam int FV_WORDS     = 4;   // power of 2, >= 2
  localparam int DATA_W       = 16;
  localparam int SRAM_LAT     = 1;   // the responder is built around a 1-cycle SRAM

  localparam int IDX_W        = $clog2(FV_WORDS);
  localparam int MEM_ADDR_W   = BANK_ADDR_W + IDX_W;

  typedef struct packed {
    logic                   valid;
    logic [PE_TAG_W-1:0]    PE_tag;
    logic [BANK_ADDR_W-1:0] FV_Bank_addr;
  } FV_MEM_CNTL2FV_Bank_CNTL;

  typedef struct packed {
    logic                valid;
    logic                last;
    logic [PE_TAG_W-1:0] PE_tag;
    logic [DATA_W-1:0]   data;
  } FV_Bank_CNTL2PE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } fv_bank_state_t;

endpackage

// File: rtl/fv_bank_rd_cntl.sv
// Per-bank FV read responder.
// Accepts one routed read request, reads FV_WORDS consecutive words of the
// addressed feature vector from the bank SRAM (1-cycle latency) and streams
// them to the PE side, one word per ISSUE/CAPTURE/HOLD round.
//
// Ports:
//  clk, reset                  clock, synchronous active-high reset
//  req_valid/req_pe_tag/req_bank_addr   request from the FV memory controller
//  bank_busy                   registered, high while a request is in flight
//  mem_en/mem_addr/mem_rdata   SRAM read port (rdata valid the cycle after mem_en)
//  out_valid/out_ready/out_data/out_pe_tag/out_last   word stream to the PE side
//  proto_err                   sticky, set when a request arrives while busy
//
// Handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both high; out_valid, out_data, out_pe_tag and out_last stay
// stable from the cycle out_valid rises until that transfer, and out_valid is
// never withdrawn without a transfer (except by reset).
//
// The FSM state is kept in state_q (fv_bank_state_t) for probing.
module fv_bank_rd_cntl
  import sys_defs::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [PE_TAG_W-1:0]    req_pe_tag,
  input  logic [BANK_ADDR_W-1:0] req_bank_addr,
  output logic                   bank_busy,
  output logic                   mem_en,
  output logic [MEM_ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [PE_TAG_W-1:0]    out_pe_tag,
  output logic                   out_last,
  output logic                   proto_err
);

  fv_bank_state_t         state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PE_TAG_W-1:0]    tag_q, tag_d;
  logic [BANK_ADDR_W-1:0] addr_q, addr_d;

  logic                   bank_busy_d;
  logic                   mem_en_d;
  logic [MEM_ADDR_W-1:0]  mem_addr_d;
  logic                   out_valid_d;
  logic [DATA_W-1:0]      out_data_d;
  logic [PE_TAG_W-1:0]    out_pe_tag_d;
  logic                   out_last_d;
  logic                   proto_err_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tag_d        = tag_q;
    addr_d       = addr_q;
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    out_pe_tag_d = out_pe_tag;
    out_last_d   = out_last;
    // A request outside IDLE is dropped but remembered as an error.
    proto_err_d  = proto_err | (req_valid && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          tag_d   = req_pe_tag;
          addr_d  = req_bank_addr;
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        out_data_d   = mem_rdata;
        out_valid_d  = 1'b1;
        out_pe_tag_d = tag_q;
        out_last_d   = (idx_q == IDX_W'(FV_WORDS - 1));
        state_d      = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ISSUE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered outputs are derived from the next state so that they line
    // up with the state they belong to.
    bank_busy_d = (state_d != IDLE);
    mem_en_d    = (state_d == ISSUE);
    // Concatenation keeps the word index out of the bank-entry field.
    mem_addr_d  = mem_en_d ? {addr_d, idx_d} : mem_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tag_q      <= '0;
      addr_q     <= '0;
      bank_busy  <= 1'b0;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_pe_tag <= '0;
      out_last   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
      bank_busy  <= bank_busy_d;
      mem_en     <= mem_en_d;
      mem_addr   <= mem_addr_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      out_pe_tag <= out_pe_tag_d;
      out_last   <= out_last_d;
      proto_err  <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_fv_bank_rd_cntl.sv
// Testbench for fv_bank_rd_cntl: directed scenarios followed by randomized
// traffic, with a behavioural 1-cycle SRAM and a transaction-level model.
module tb_fv_bank_rd_cntl;

  localparam int PE_TAG_W    = sys_defs::PE_TAG_W;
  localparam int BANK_ADDR_W = sys_defs::BANK_ADDR_W;
  localparam int FV_WORDS    = sys_defs::FV_WORDS;
  localparam int DATA_W      = sys_defs::DATA_W;
  localparam int MEM_ADDR_W  = sys_defs::MEM_ADDR_W;
  localparam int MEM_DEPTH   = 1 << MEM_ADDR_W;
  localparam int EW          = PE_TAG_W + 1 + DATA_W;

  // ---------------- clock / reset / DUT ----------------
  logic                   clk;
  logic                   reset;
  logic                   req_valid;
  logic [PE_TAG_W-1:0]    req_pe_tag;
  logic [BANK_ADDR_W-1:0] req_bank_addr;
  logic                   bank_busy;
  logic                   mem_en;
  logic [MEM_ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]      mem_rdata;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [PE_TAG_W-1:0]    out_pe_tag;
  logic                   out_last;
  logic                   proto_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fv_bank_rd_cntl dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_pe_tag    (req_pe_tag),
    .req_bank_addr (req_bank_addr),
    .bank_busy     (bank_busy),
    .mem_en        (mem_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_pe_tag    (out_pe_tag),
    .out_last      (out_last),
    .proto_err     (proto_err)
  );

  // Behavioural SRAM, read data one cycle after mem_en.
  logic [DATA_W-1:0] sram [MEM_DEPTH];
  initial mem_rdata = '0;
  always @(posedge clk) if (mem_en) mem_rdata <= sram[mem_addr];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [EW-1:0]         exp_q[$];   // {tag, last, data} per expected word
  logic [MEM_ADDR_W-1:0] addr_q[$];  // expected SRAM read addresses in order
  bit                    mon_on = 0;
  bit                    m_busy = 0;
  bit                    m_perr = 0;
  bit                    m_after_rst = 0;
  int                    m_left = 0;
  bit                    hold_prev = 0;
  logic [EW-1:0]         prev_word;

  always @(negedge clk) begin
    bit cur_busy;
    cur_busy = m_busy;
    if (mon_on) begin
      check("busy", {31'b0, bank_busy}, {31'b0, m_busy});
      check("proto_err", {31'b0, proto_err}, {31'b0, m_perr});
      if (m_after_rst) begin
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_last", {31'b0, out_last}, 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_tag", 32'(out_pe_tag), 0);
        check("rst_mem_en", {31'b0, mem_en}, 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
      end
      if (mem_en) begin
        check("read_while_held", {31'b0, out_valid}, 0);
        check("read_expected", {31'b0, addr_q.size() > 0}, 1);
        if (addr_q.size() > 0) check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
      if (out_valid) check("valid_when_idle", {31'b0, m_busy}, 1);
      if (hold_prev) begin
        check("hold_valid", {31'b0, out_valid}, 1);
        check("hold_word", 32'({out_pe_tag, out_last, out_data}), 32'(prev_word));
      end
      if (out_valid && out_ready) begin
        check("word_expected", {31'b0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0)
          check("word", 32'({out_pe_tag, out_last, out_data}), 32'(exp_q.pop_front()));
      end
    end
    // predict the next cycle
    if (reset) begin
      exp_q.delete();
      addr_q.delete();
      m_busy = 0; m_perr = 0; m_left = 0;
      m_after_rst = 1; hold_prev = 0;
      mon_on = 1;
    end else if (mon_on) begin
      m_after_rst = 0;
      hold_prev = out_valid && !out_ready;
      prev_word = {out_pe_tag, out_last, out_data};
      if (out_valid && out_ready && m_left > 0) begin
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
      if (req_valid) begin
        if (cur_busy) m_perr = 1;
        else begin
          for (int i = 0; i < FV_WORDS; i++) begin
            int a;
            a = int'(req_bank_addr) * FV_WORDS + i;
            addr_q.push_back(MEM_ADDR_W'(a));
            exp_q.push_back({req_pe_tag, (i == FV_WORDS - 1) ? 1'b1 : 1'b0, sram[a]});
          end
          m_busy = 1;
          m_left = FV_WORDS;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit v, input int tag, input int addr);
    req_valid     = v;
    req_pe_tag    = PE_TAG_W'(tag);
    req_bank_addr = BANK_ADDR_W'(addr);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!bank_busy && exp_q.size() == 0) done = 1;
    end
    check("idle_timeout", {31'b0, done}, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1; out_ready = 1;
    set_req(0, 0, 0);
    for (int i = 0; i < MEM_DEPTH; i++) sram[i] = DATA_W'(i);
    repeat (3) cyc();
    reset = 0;
    cyc();

    // 1: single request, cycle-exact timing
    set_req(1, 2, 1);
    for (int c = 1; c <= 13; c++) begin
      bit ev, ee;
      cyc();
      if (c == 1) set_req(0, 0, 0);
      @(negedge clk);
      ev = (c % 3 == 0) && (c <= 12);
      ee = (c % 3 == 1) && (c <= 10);
      check("t1_busy", {31'b0, bank_busy}, {31'b0, c <= 12});
      check("t1_valid", {31'b0, out_valid}, {31'b0, ev});
      check("t1_mem_en", {31'b0, mem_en}, {31'b0, ee});
      if (ev) begin
        check("t1_data", 32'(out_data), 4 + c / 3 - 1);
        check("t1_last", {31'b0, out_last}, {31'b0, c == 12});
        check("t1_tag", 32'(out_pe_tag), 2);
      end
      if (ee) check("t1_addr", 32'(mem_addr), 4 + (c - 1) / 3);
    end

    // 2: backpressure while word 1 is held
    cyc();
    set_req(1, 0, 2);
    for (int c = 1; c <= 11; c++) begin
      cyc();
      if (c == 1) set_req(0, 0, 0);
      if (c == 6) out_ready = 0;
      if (c == 11) out_ready = 1;
      if (c >= 6 && c <= 10) begin
        @(negedge clk);
        check("t2_hold_data", 32'(out_data), 9);
        check("t2_hold_valid", {31'b0, out_valid}, 1);
        check("t2_no_read", {31'b0, mem_en}, 0);
        check("t2_hold_addr", 32'(mem_addr), 9);
      end
    end
    wait_idle(60);

    // 3: request while busy is ignored and flagged
    cyc();
    set_req(1, 2, 3);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c == 1) set_req(0, 0, 0);
      if (c == 4) set_req(1, 1, 0);
      if (c == 5) set_req(0, 0, 0);
    end
    wait_idle(60);
    repeat (3) cyc();
    @(negedge clk);
    check("t3_perr_sticky", {31'b0, proto_err}, 1);

    // 4: reset during HOLD of word 2, then top entry of the bank
    cyc();
    set_req(1, 1, 2);
    for (int c = 1; c <= 14; c++) begin
      cyc();
      if (c == 1) set_req(0, 0, 0);
      if (c == 9) out_ready = 0;
      if (c == 10) reset = 1;
      if (c == 11) begin
        reset = 0; out_ready = 1;
        @(negedge clk);
        check("t4_rst_valid", {31'b0, out_valid}, 0);
        check("t4_rst_busy", {31'b0, bank_busy}, 0);
        check("t4_rst_perr", {31'b0, proto_err}, 0);
        check("t4_rst_mem_en", {31'b0, mem_en}, 0);
      end
      if (c == 13) set_req(1, 3, 3);
      if (c == 14) set_req(0, 0, 0);
    end
    wait_idle(60);

    // 5: back-to-back request in the first idle cycle
    cyc();
    set_req(1, 0, 0);
    cyc();
    set_req(0, 0, 0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (out_valid && out_ready && out_last) seen = 1;
      end
      check("t5_last_seen", {31'b0, seen}, 1);
    end
    cyc();
    set_req(1, 3, 1);
    @(negedge clk);
    check("t5_idle_gap", {31'b0, bank_busy}, 0);
    cyc();
    set_req(0, 0, 0);
    @(negedge clk);
    check("t5_busy_again", {31'b0, bank_busy}, 1);
    wait_idle(60);

    // 6: request together with reset is not accepted
    cyc();
    reset = 1;
    set_req(1, 2, 2);
    cyc();
    reset = 0;
    set_req(0, 0, 0);
    @(negedge clk);
    check("t6_busy", {31'b0, bank_busy}, 0);
    cyc();
    @(negedge clk);
    check("t6_busy2", {31'b0, bank_busy}, 0);
    check("t6_mem_en", {31'b0, mem_en}, 0);

    // randomized traffic
    for (int i = 0; i < MEM_DEPTH; i++) sram[i] = DATA_W'($urandom_range(0, 65535));
    for (int n = 0; n < 500; n++) begin
      cyc();
      set_req($urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom_range(0, 3));
      out_ready = ($urandom_range(0, 9) < 7);
      reset     = ($urandom_range(0, 99) == 0);
    end
    cyc();
    set_req(0, 0, 0);
    reset = 0;
    out_ready = 1;
    wait_idle(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
